// File: rtl/field_unpacker_if.sv
// Stream and status bundle for the field unpacker: packed words in,
// split a/b/c fields out, plus occupancy and the sticky overflow flag.
interface field_unpacker_if #(
    parameter int A_W   = 1,
    parameter int B_W   = 2,
    parameter int C_W   = 2,
    parameter int DEPTH = 4
);
    localparam int W  = A_W + B_W + C_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_word;
    logic          out_valid;
    logic          out_ready;
    logic [A_W-1:0] out_a;
    logic [B_W-1:0] out_b;
    logic [C_W-1:0] out_c;
    logic [CW-1:0] count;
    logic          overflow;
    logic          clr_ovf;

    // Producer/consumer side that drives words and takes fields.
    modport master (
        output in_valid, in_word, out_ready, clr_ovf,
        input  in_ready, out_valid, out_a, out_b, out_c, count, overflow
    );

    // The unpacker itself.
    modport slave (
        input  in_valid, in_word, out_ready, clr_ovf,
        output in_ready, out_valid, out_a, out_b, out_c, count, overflow
    );
endinterface

// File: rtl/field_unpacker.sv
// Receive end of the field-packing path: buffers packed {a,b,c} words in a
// small FIFO and presents the head word split into its fields. Words offered
// while full are dropped and latched into a sticky overflow flag.
module field_unpacker #(
    parameter int A_W   = 1,
    parameter int B_W   = 2,
    parameter int C_W   = 2,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    field_unpacker_if.slave bus
);
    localparam int W  = A_W + B_W + C_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_head;

    // Ready depends only on registered occupancy, so a full FIFO refuses a
    // word even when the consumer is popping in the same cycle.
    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Head entry is forced to zero when empty so stale storage never leaks.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_a     = w_head[W-1 -: A_W];
    assign bus.out_b     = w_head[C_W+B_W-1 -: B_W];
    assign bus.out_c     = w_head[C_W-1:0];
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;

    // Storage write; the array carries no reset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_word;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a refused offer sets it and beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.in_valid && !w_in_ready) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_field_unpacker.sv
// Directed bench for field_unpacker: reset, field split and hold, fill and
// overflow, clear priority, concurrent push/pop with pointer wrap, empty pop
// and asynchronous reset mid-run.
module tb_field_unpacker;
    localparam int A_W   = 1;
    localparam int B_W   = 2;
    localparam int C_W   = 2;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    field_unpacker_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .DEPTH(DEPTH)) bus ();

    field_unpacker #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] head();
        return 32'({bus.out_a, bus.out_b, bus.out_c});
    endfunction

    task automatic push(input logic [4:0] w);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    logic [4:0] fill_words [5];
    logic [4:0] hold_word;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        fill_words[0] = 5'h11; fill_words[1] = 5'h05; fill_words[2] = 5'h1A;
        fill_words[3] = 5'h0F; fill_words[4] = 5'h13;

        // Reset state
        step();
        step();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_fields", head(), 32'd0);
        rst = 1'b0;
        step();

        // Field split with no bypass, then hold under stall
        bus.in_valid = 1'b1;
        bus.in_word  = 5'b1_10_01;
        #1;
        check("split_no_bypass", 32'(bus.out_valid), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("split_out_valid", 32'(bus.out_valid), 32'd1);
        check("split_a", 32'(bus.out_a), 32'd1);
        check("split_b", 32'(bus.out_b), 32'd2);
        check("split_c", 32'(bus.out_c), 32'd1);
        check("split_count", 32'(bus.count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), head(), 32'h19);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("split_drained", 32'(bus.count), 32'd0);

        // Fill to full, fifth word dropped
        for (int i = 0; i < 4; i++) push(fill_words[i]);
        check("fill_count", 32'(bus.count), 32'd4);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_no_ovf_yet", 32'(bus.overflow), 32'd0);
        push(fill_words[4]);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), head(), 32'(fill_words[i]));
            step();
        end
        bus.out_ready = 1'b0;
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_count", 32'(bus.count), 32'd0);

        // Overflow clear, and set-beats-clear when full
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 4; i++) push(5'(i + 3));
        bus.in_valid = 1'b1;
        bus.in_word  = 5'h1F;
        bus.clr_ovf  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.clr_ovf  = 1'b0;
        check("ovf_set_wins", 32'(bus.overflow), 32'd1);
        bus.clr_ovf   = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain2_%0d", i), head(), 32'(i + 3));
            step();
            bus.clr_ovf = 1'b0;
        end
        bus.out_ready = 1'b0;
        check("drain2_count", 32'(bus.count), 32'd0);
        check("drain2_ovf", 32'(bus.overflow), 32'd0);

        // Concurrent push and pop at count 2, crossing the pointer wrap
        push(5'd0);
        push(5'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = 5'(i + 2);
            #1;
            check($sformatf("pp_head_%0d", i), head(), 32'(i));
            step();
            check($sformatf("pp_count_%0d", i), 32'(bus.count), 32'd2);
        end
        bus.in_valid = 1'b0;
        check("pp_tail_6", head(), 32'd6);
        step();
        check("pp_tail_7", head(), 32'd7);
        step();
        bus.out_ready = 1'b0;
        check("pp_empty", 32'(bus.count), 32'd0);

        // Pop while empty is ignored
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("empty_count_%0d", i), 32'(bus.count), 32'd0);
            check($sformatf("empty_fields_%0d", i), head(), 32'd0);
        end
        bus.out_ready = 1'b0;
        push(5'h0A);
        check("after_empty_head", head(), 32'h0A);
        check("after_empty_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-run with three words buffered
        push(5'h01);
        push(5'h02);
        push(5'h03);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_fields", head(), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        #1;
        rst = 1'b0;
        push(5'h15);
        check("post_rst_head", head(), 32'h15);
        check("post_rst_count", 32'(bus.count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
